mac_array_acc: RTL and testbench

- Parametrised successor to the fixed 8-channel MAC top.
- NUM_CH output channels each multiply a shared NUM_LANES-wide activation vector by a per-channel weight vector.
- Per-channel products are reduced, accumulated over a multi-beat job framed by first/last flags, then requantised (arithmetic shift plus saturation) to OUT_W.
- Sits between the activation/weight buffers and the output feature-map writer; accepts one beat per cycle, fully pipelined.

---
 rtl/mac_pkg.sv | 34 +++
 rtl/mac_lane_tree.sv | 47 ++++
 rtl/mac_array_acc.sv | 151 +++++++++++++++
 tb/tb_mac_array_acc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths, helper functions and accumulator state encoding for the
// multi-channel MAC array.
package mac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_WGT_W  = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_OUT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } acc_state_t;

    function automatic int tree_width(input int data_w, input int wgt_w, input int lanes);
        return data_w + wgt_w + $clog2(lanes);
    endfunction

    // Clamp a signed value into the range of an out_w-bit signed number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                    input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (val > hi)
            return hi;
        else if (val < lo)
            return lo;
        else
            return val;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// One output channel: NUM_LANES signed multipliers (S1) feeding a registered
// adder tree (S2).
module mac_lane_tree #(
    parameter int NUM_LANES = 16,
    parameter int DATA_W    = 8,
    parameter int WGT_W     = 8,
    parameter int SUM_W     = 20
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_LANES*DATA_W-1:0]   din,
    input  logic [NUM_LANES*WGT_W-1:0]    weight,
    output logic signed [SUM_W-1:0]       sum
);

    localparam int PROD_W = DATA_W + WGT_W;

    logic signed [PROD_W-1:0] prod_c [NUM_LANES];
    logic signed [PROD_W-1:0] prod   [NUM_LANES];
    logic signed [SUM_W-1:0]  tree_c;

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            prod_c[k] = PROD_W'($signed(din[k*DATA_W +: DATA_W]))
                      * PROD_W'($signed(weight[k*WGT_W +: WGT_W]));
        end
    end

    // Written as a chain; synthesis balances it into a tree.
    always_comb begin
        tree_c = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            tree_c = tree_c + SUM_W'(prod[k]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod <= '{default: '0};
            sum  <= '0;
        end else begin
            prod <= prod_c;
            sum  <= tree_c;
        end
    end

endmodule

// File: rtl/mac_array_acc.sv
// NUM_CH-channel MAC array: per-channel dot products accumulated over a
// first/last framed job, then requantised (shift + saturate) to OUT_W.
//
// state | meaning
// IDLE  | no job open; a beat must carry first
// RUN   | job open; accumulating until the last beat
module mac_array_acc
    import mac_pkg::*;
#(
    parameter int NUM_LANES = 16,
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WGT_W     = DEF_WGT_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             vld_i,
    input  logic                             first_i,
    input  logic                             last_i,
    input  logic [NUM_LANES*DATA_W-1:0]      din,
    input  logic [NUM_CH*NUM_LANES*WGT_W-1:0] weight,
    input  logic [5:0]                       shift_i,
    output logic [NUM_CH*OUT_W-1:0]          sum_o,
    output logic                             vld_o,
    output logic [CNT_W-1:0]                 beats_o,
    output logic                             err_o
);

    localparam int TREE_W = tree_width(DATA_W, WGT_W, NUM_LANES);

    logic signed [TREE_W-1:0] ch_sum [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mac_lane_tree #(
            .NUM_LANES(NUM_LANES),
            .DATA_W   (DATA_W),
            .WGT_W    (WGT_W),
            .SUM_W    (TREE_W)
        ) u_tree (
            .clk   (clk),
            .rstn  (rstn),
            .din   (din),
            .weight(weight[c*NUM_LANES*WGT_W +: NUM_LANES*WGT_W]),
            .sum   (ch_sum[c])
        );
    end

    // Framing sidebands ride alongside the S1/S2 data registers.
    logic       s1_vld, s1_first, s1_last;
    logic [5:0] s1_shift;
    logic       s2_vld, s2_first, s2_last;
    logic [5:0] s2_shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_shift <= '0;
            s2_vld   <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_shift <= '0;
        end else begin
            s1_vld   <= vld_i;
            s1_first <= first_i;
            s1_last  <= last_i;
            s1_shift <= shift_i;
            s2_vld   <= s1_vld;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_shift <= s1_shift;
        end
    end

    acc_state_t              state;
    logic signed [ACC_W-1:0] acc [NUM_CH];
    logic [CNT_W-1:0]        cnt;
    logic                    s3_emit, s3_err;
    logic [5:0]              s3_shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            acc      <= '{default: '0};
            cnt      <= '0;
            s3_emit  <= 1'b0;
            s3_err   <= 1'b0;
            s3_shift <= '0;
        end else begin
            s3_emit <= 1'b0;
            s3_err  <= 1'b0;
            if (s2_vld) begin
                if (s2_first) begin
                    // A first inside an open job abandons the old job.
                    if (state == RUN)
                        s3_err <= 1'b1;
                    for (int c = 0; c < NUM_CH; c++)
                        acc[c] <= ACC_W'(ch_sum[c]);
                    cnt      <= CNT_W'(1);
                    s3_emit  <= s2_last;
                    s3_shift <= s2_shift;
                    state    <= s2_last ? IDLE : RUN;
                end else if (state == RUN) begin
                    for (int c = 0; c < NUM_CH; c++)
                        acc[c] <= acc[c] + ACC_W'(ch_sum[c]);
                    if (cnt != '1)
                        cnt <= cnt + CNT_W'(1);
                    s3_emit  <= s2_last;
                    s3_shift <= s2_shift;
                    if (s2_last)
                        state <= IDLE;
                end else begin
                    s3_err <= 1'b1;
                end
            end
        end
    end

    logic [NUM_CH*OUT_W-1:0] sat_c;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        sat_c   = '0;
        shifted = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            shifted = acc[c] >>> s3_shift;
            sat_c[c*OUT_W +: OUT_W] = OUT_W'(saturate(64'(shifted), OUT_W));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_o   <= '0;
            beats_o <= '0;
            vld_o   <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            vld_o <= s3_emit;
            err_o <= s3_err;
            if (s3_emit) begin
                sum_o   <= sat_c;
                beats_o <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_acc.sv
// Directed bench for mac_array_acc: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every vld_o/err_o.
module tb_mac_array_acc;

    localparam int NL = 16;
    localparam int NC = 8;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int CW = 16;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                vld_i = 1'b0;
    logic                first_i = 1'b0;
    logic                last_i = 1'b0;
    logic [NL*DW-1:0]    din = '0;
    logic [NC*NL*WW-1:0] weight = '0;
    logic [5:0]          shift_i = '0;
    logic [NC*OW-1:0]    sum_o;
    logic                vld_o;
    logic [CW-1:0]       beats_o;
    logic                err_o;

    typedef struct {
        logic             vld;
        logic             err;
        logic [NC*OW-1:0] sum;
        logic [CW-1:0]    beats;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    logic [NC*OW-1:0] exp_sum = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_array_acc #(
        .NUM_LANES(NL), .NUM_CH(NC), .DATA_W(DW), .WGT_W(WW),
        .ACC_W(AW), .OUT_W(OW), .CNT_W(CW)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .vld_i  (vld_i),
        .first_i(first_i),
        .last_i (last_i),
        .din    (din),
        .weight (weight),
        .shift_i(shift_i),
        .sum_o  (sum_o),
        .vld_o  (vld_o),
        .beats_o(beats_o),
        .err_o  (err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic set_din_all(input int v);
        for (int k = 0; k < NL; k++) din[k*DW +: DW] = DW'(v);
    endtask

    task automatic set_wgt(input int c, input int v);
        for (int k = 0; k < NL; k++) weight[(c*NL+k)*WW +: WW] = WW'(v);
    endtask

    task automatic set_exp(input int c, input int v);
        exp_sum[c*OW +: OW] = OW'(v);
    endtask

    task automatic set_exp_all(input int v);
        for (int c = 0; c < NC; c++) set_exp(c, v);
    endtask

    // Called at drive time: the result is due four edges after this cycle.
    task automatic expect_out(input bit v, input bit e, input int beats);
        exp_t x;
        x.vld   = v;
        x.err   = e;
        x.sum   = exp_sum;
        x.beats = CW'(beats);
        x.cyc   = cyc + 4;
        sb.push_back(x);
    endtask

    task automatic beat(input bit f, input bit l, input int sh);
        vld_i   = 1'b1;
        first_i = f;
        last_i  = l;
        shift_i = 6'(sh);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vld_i   = 1'b0;
        first_i = 1'b0;
        last_i  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (vld_o || err_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got vld=%0b err=%0b, required none", vld_o, err_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("vld_o", 64'(vld_o), 64'(e.vld));
                chk("err_o", 64'(err_o), 64'(e.err));
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                if (e.vld) begin
                    chk("sum_o", 64'(sum_o), 64'(e.sum));
                    chk("beats_o", 64'(beats_o), 64'(e.beats));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        chk("reset_sum_o", 64'(sum_o), 64'(0));
        chk("reset_beats_o", 64'(beats_o), 64'(0));
        chk("reset_vld_o", 64'(vld_o), 64'(0));
        chk("reset_err_o", 64'(err_o), 64'(0));
        rstn = 1'b1;
        idle(2);

        // Single-beat job: 16 lanes of 1*1
        set_din_all(1);
        for (int c = 0; c < NC; c++) set_wgt(c, 1);
        set_exp_all(16);
        expect_out(1, 0, 1);
        beat(1, 1, 0);
        idle(8);

        // 3-beat job, ch0 -48 >>> 2 = -12, ch1 48 >>> 2 = 12, others 0
        for (int c = 0; c < NC; c++) set_wgt(c, 0);
        set_wgt(0, -1);
        set_wgt(1, 1);
        set_exp_all(0);
        set_exp(0, -12);
        set_exp(1, 12);
        beat(1, 0, 0);
        beat(0, 0, 0);
        expect_out(1, 0, 3);
        beat(0, 1, 2);
        idle(8);

        // Saturation: even channels +1,032,256 -> 127, odd -1,040,384 -> -128
        set_din_all(127);
        for (int c = 0; c < NC; c++) begin
            set_wgt(c, (c % 2 == 0) ? 127 : -128);
            set_exp(c, (c % 2 == 0) ? 127 : -128);
        end
        beat(1, 0, 0);
        beat(0, 0, 0);
        beat(0, 0, 0);
        expect_out(1, 0, 4);
        beat(0, 1, 0);
        idle(8);

        // Truncation toward -inf: -50 >>> 2 = -13, 50 >>> 2 = 12
        set_din_all(0);
        din[DW-1:0] = DW'(-50);
        for (int c = 0; c < NC; c++) begin
            set_wgt(c, (c % 2 == 0) ? 1 : -1);
            set_exp(c, (c % 2 == 0) ? -13 : 12);
        end
        expect_out(1, 0, 1);
        beat(1, 1, 2);
        idle(8);

        // Beat without first while idle: error only
        set_din_all(1);
        for (int c = 0; c < NC; c++) set_wgt(c, 1);
        expect_out(0, 1, 0);
        beat(0, 1, 0);
        idle(8);

        // First mid-job restarts: only the second job's 32 is emitted
        beat(1, 0, 0);
        set_din_all(2);
        set_exp_all(32);
        expect_out(1, 1, 1);
        beat(1, 1, 0);
        idle(8);

        // Back-to-back single-beat jobs: 16, 32, 48 on consecutive cycles
        for (int j = 1; j <= 3; j++) begin
            set_din_all(j);
            set_exp_all(16 * j);
            expect_out(1, 0, 1);
            beat(1, 1, 0);
        end
        idle(8);

        // Reset during beat 2 of a 4-beat job
        set_din_all(1);
        beat(1, 0, 0);
        vld_i   = 1'b1;
        first_i = 1'b0;
        last_i  = 1'b0;
        rstn    = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_sum_o", 64'(sum_o), 64'(0));
        chk("midreset_beats_o", 64'(beats_o), 64'(0));
        chk("midreset_vld_o", 64'(vld_o), 64'(0));
        chk("midreset_err_o", 64'(err_o), 64'(0));
        idle(2);
        rstn = 1'b1;
        idle(2);
        set_din_all(3);
        set_exp_all(48);
        expect_out(1, 0, 1);
        beat(1, 1, 0);
        idle(10);

        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
